// File: rtl/reg_read_stage_pkg.sv
// -----------------------------------------------------------------------------
// reg_read_stage_pkg
//   Shared widths, operand/command enums and the execute packet used by the
//   register-read stage, its register file and its bus interface.
//   No ports (package).
// -----------------------------------------------------------------------------
package reg_read_stage_pkg;

    localparam int DISPATCH_WIDTH       = 2;
    localparam int PHYS_REGS_ADDR_WIDTH = 6;
    localparam int ROB_ADDR_WIDTH       = 5;
    localparam int DISPATCH_ADDR_WIDTH  = 3;
    localparam int XLEN                 = 32;

    typedef logic [XLEN-1:0]                 word_t;
    typedef logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_addr_t;
    typedef logic [ROB_ADDR_WIDTH-1:0]       rob_addr_t;
    typedef logic [DISPATCH_ADDR_WIDTH-1:0]  bank_addr_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_cmd_t;

    // REG: low PHYS_REGS_ADDR_WIDTH bits of op2 name the source register.
    // IMM: op2 itself is the operand.
    typedef enum logic {
        OP_REG = 1'b0,
        OP_IMM = 1'b1
    } op_type_t;

    // One bank's worth of execute payload; lets the ex_* bundle later become
    // its own interface without touching the stage internals.
    typedef struct packed {
        alu_cmd_t   alu_cmd;
        word_t      op1_data;
        word_t      op2_data;
        phys_addr_t phys_rd;
        bank_addr_t bank_addr;
        rob_addr_t  rob_addr;
    } ex_packet_t;

endpackage

// File: rtl/reg_read_stage_if.sv
// -----------------------------------------------------------------------------
// reg_read_stage_if
//   Issue, writeback and execute buses of the register-read stage.
//   master : issue queue / writeback side (drives issue_*, wb_*)
//   slave  : reg_read_stage (drives ex_*, wb_dup)
//   Signals, one entry per dispatch bank:
//     issue_valid/alu_cmd/op1/op2_type/op2/phys_rd/bank_addr/rob_addr
//     wb_valid/wb_phys_rd/wb_data
//     ex_valid/alu_cmd/op1_data/op2_data/phys_rd/bank_addr/rob_addr
//     wb_dup : two or more banks write the same non-zero register this cycle
// -----------------------------------------------------------------------------
interface reg_read_stage_if;
    import reg_read_stage_pkg::*;

    logic       [DISPATCH_WIDTH-1:0] issue_valid;
    alu_cmd_t   [DISPATCH_WIDTH-1:0] issue_alu_cmd;
    phys_addr_t [DISPATCH_WIDTH-1:0] issue_op1;
    op_type_t   [DISPATCH_WIDTH-1:0] issue_op2_type;
    word_t      [DISPATCH_WIDTH-1:0] issue_op2;
    phys_addr_t [DISPATCH_WIDTH-1:0] issue_phys_rd;
    bank_addr_t [DISPATCH_WIDTH-1:0] issue_bank_addr;
    rob_addr_t  [DISPATCH_WIDTH-1:0] issue_rob_addr;

    logic       [DISPATCH_WIDTH-1:0] wb_valid;
    phys_addr_t [DISPATCH_WIDTH-1:0] wb_phys_rd;
    word_t      [DISPATCH_WIDTH-1:0] wb_data;

    logic       [DISPATCH_WIDTH-1:0] ex_valid;
    alu_cmd_t   [DISPATCH_WIDTH-1:0] ex_alu_cmd;
    word_t      [DISPATCH_WIDTH-1:0] ex_op1_data;
    word_t      [DISPATCH_WIDTH-1:0] ex_op2_data;
    phys_addr_t [DISPATCH_WIDTH-1:0] ex_phys_rd;
    bank_addr_t [DISPATCH_WIDTH-1:0] ex_bank_addr;
    rob_addr_t  [DISPATCH_WIDTH-1:0] ex_rob_addr;

    logic                            wb_dup;

    modport master (
        output issue_valid, issue_alu_cmd, issue_op1, issue_op2_type, issue_op2,
               issue_phys_rd, issue_bank_addr, issue_rob_addr,
               wb_valid, wb_phys_rd, wb_data,
        input  ex_valid, ex_alu_cmd, ex_op1_data, ex_op2_data,
               ex_phys_rd, ex_bank_addr, ex_rob_addr, wb_dup
    );

    modport slave (
        input  issue_valid, issue_alu_cmd, issue_op1, issue_op2_type, issue_op2,
               issue_phys_rd, issue_bank_addr, issue_rob_addr,
               wb_valid, wb_phys_rd, wb_data,
        output ex_valid, ex_alu_cmd, ex_op1_data, ex_op2_data,
               ex_phys_rd, ex_bank_addr, ex_rob_addr, wb_dup
    );

endinterface

// File: rtl/reg_read_stage_phys_reg_file.sv
// -----------------------------------------------------------------------------
// reg_read_stage_phys_reg_file
//   Physical register file, NUM_REGS x 32, p0 hard-wired to zero.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset (clears every entry)
//     i_rd_addr    : NUM_RD asynchronous read addresses
//     o_rd_data    : read data, with same-cycle write data bypassed in
//     i_wr_en/addr/data : NUM_WR write ports, committed at posedge
//     o_wr_dup     : two write ports target the same non-zero register
//   On address collisions the highest-numbered write port wins, both for the
//   stored value and for the bypass.
// -----------------------------------------------------------------------------
module reg_read_stage_phys_reg_file
    import reg_read_stage_pkg::*;
#(
    parameter int NUM_REGS = 64,
    parameter int NUM_WR   = DISPATCH_WIDTH,
    parameter int NUM_RD   = 2 * DISPATCH_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  phys_addr_t [NUM_RD-1:0] i_rd_addr,
    output word_t      [NUM_RD-1:0] o_rd_data,
    input  logic       [NUM_WR-1:0] i_wr_en,
    input  phys_addr_t [NUM_WR-1:0] i_wr_addr,
    input  word_t      [NUM_WR-1:0] i_wr_data,
    output logic                    o_wr_dup
);

    word_t r_regs [NUM_REGS];

    // NOTE: the whole array is cleared on reset because software-visible
    // state must start at zero; this keeps it a flop array, not an SRAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking writes; with several ports hitting one index
            // the last assignment in loop order (highest port) takes effect.
            for (int k = 0; k < NUM_WR; k++) begin
                if (i_wr_en[k] && (i_wr_addr[k] != '0)) begin
                    r_regs[i_wr_addr[k]] <= i_wr_data[k];
                end
            end
        end
    end

    // NOTE: each output gets its array value first, so every path assigns
    // it and no latch is inferred; bypass and p0 then override in order.
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            o_rd_data[p] = r_regs[i_rd_addr[p]];
            for (int k = 0; k < NUM_WR; k++) begin
                if (i_wr_en[k] && (i_wr_addr[k] == i_rd_addr[p])) begin
                    o_rd_data[p] = i_wr_data[k];
                end
            end
            // p0 never bypasses, even when a bank writes p0 this cycle.
            if (i_rd_addr[p] == '0) begin
                o_rd_data[p] = '0;
            end
        end
    end

    always_comb begin
        o_wr_dup = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (i_wr_en[i] && i_wr_en[j] && (i_wr_addr[i] == i_wr_addr[j])
                    && (i_wr_addr[i] != '0)) begin
                    o_wr_dup = 1'b1;
                end
            end
        end
    end

    // Duplicate writes are resolved deterministically but usually indicate a
    // rename bug upstream, so flag them in simulation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!o_wr_dup)
            else $warning("duplicate wb_phys_rd in one cycle, highest bank kept");
        end
    end

endmodule

// File: rtl/reg_read_stage.sv
// -----------------------------------------------------------------------------
// reg_read_stage
//   Register-read stage behind the issue queue. Reads both source operands of
//   up to DISPATCH_WIDTH issued ops from the physical register file (with
//   same-cycle writeback bypass) and registers an execute packet per bank.
//   Ports:
//     clk     : clock
//     rst     : synchronous active-high reset (priority over everything)
//     i_flush : squash the ops issued this cycle (regfile writes still land)
//     io_rr   : reg_read_stage_if.slave (issue_*, wb_* in; ex_*, wb_dup out)
//   Latency: issue in cycle N -> ex_valid in cycle N+1, no backpressure.
// -----------------------------------------------------------------------------
module reg_read_stage
    import reg_read_stage_pkg::*;
#(
    parameter int NUM_PHYS_REGS = 64  // must equal 2**PHYS_REGS_ADDR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    reg_read_stage_if.slave  io_rr
);

    localparam int DW = DISPATCH_WIDTH;

    // Read port 2b serves op1 of bank b, port 2b+1 serves op2 of bank b.
    phys_addr_t [2*DW-1:0] w_rd_addr;
    word_t      [2*DW-1:0] w_rd_data;
    ex_packet_t [DW-1:0]   w_ex_next;
    logic                  w_wb_dup;

    ex_packet_t [DW-1:0]   r_ex_pkt;
    logic       [DW-1:0]   r_ex_valid;

    always_comb begin
        for (int b = 0; b < DW; b++) begin
            w_rd_addr[2*b]   = io_rr.issue_op1[b];
            w_rd_addr[2*b+1] = io_rr.issue_op2[b][PHYS_REGS_ADDR_WIDTH-1:0];
        end
    end

    reg_read_stage_phys_reg_file #(
        .NUM_REGS (NUM_PHYS_REGS),
        .NUM_WR   (DW),
        .NUM_RD   (2 * DW)
    ) u_prf (
        .clk       (clk),
        .rst       (rst),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data),
        .i_wr_en   (io_rr.wb_valid),
        .i_wr_addr (io_rr.wb_phys_rd),
        .i_wr_data (io_rr.wb_data),
        .o_wr_dup  (w_wb_dup)
    );

    always_comb begin
        for (int b = 0; b < DW; b++) begin
            w_ex_next[b].alu_cmd   = io_rr.issue_alu_cmd[b];
            w_ex_next[b].op1_data  = w_rd_data[2*b];
            w_ex_next[b].op2_data  = (io_rr.issue_op2_type[b] == OP_IMM)
                                   ? io_rr.issue_op2[b] : w_rd_data[2*b+1];
            w_ex_next[b].phys_rd   = io_rr.issue_phys_rd[b];
            w_ex_next[b].bank_addr = io_rr.issue_bank_addr[b];
            w_ex_next[b].rob_addr  = io_rr.issue_rob_addr[b];
        end
    end

    // Payload loads every cycle; only the valid bits are squashed by flush,
    // so payload behind a cleared valid is stale but never X after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid <= '0;
            r_ex_pkt   <= '0;
        end else begin
            r_ex_valid <= i_flush ? '0 : io_rr.issue_valid;
            r_ex_pkt   <= w_ex_next;
        end
    end

    always_comb begin
        io_rr.ex_valid = r_ex_valid;
        for (int b = 0; b < DW; b++) begin
            io_rr.ex_alu_cmd[b]   = r_ex_pkt[b].alu_cmd;
            io_rr.ex_op1_data[b]  = r_ex_pkt[b].op1_data;
            io_rr.ex_op2_data[b]  = r_ex_pkt[b].op2_data;
            io_rr.ex_phys_rd[b]   = r_ex_pkt[b].phys_rd;
            io_rr.ex_bank_addr[b] = r_ex_pkt[b].bank_addr;
            io_rr.ex_rob_addr[b]  = r_ex_pkt[b].rob_addr;
        end
    end

    assign io_rr.wb_dup = w_wb_dup;

endmodule
